// File: rtl/rv_fetch_buffer_pkg.sv
// rtl/rv_fetch_buffer_pkg.sv - shared constants for the fetch stage
package rv_fetch_buffer_pkg;

   // addi x0, x0, 0: the bubble decode sees whenever the queue is empty
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/rv_sync_fifo.sv
// rtl/rv_sync_fifo.sv - DEPTH x WIDTH synchronous FIFO with flush, no bypass
module rv_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                         clk_i,
   input  logic                         resetn_i,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // a push into a full FIFO is accepted only when the head leaves the same cycle
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/rv_fetch_buffer.sv
// rtl/rv_fetch_buffer.sv - credit-based instruction prefetch queue in front of decode
module rv_fetch_buffer
   import rv_fetch_buffer_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            resetn_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_add_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_data_i,
   output logic            inst_valid_o,
   output logic [31:0]     inst_o,
   output logic [XLEN-1:0] inst_pc_o,
   input  logic            inst_ready_i
);
   localparam int CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [31:0]     inst;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [XLEN-1:0] target_pc;
   logic [CW-1:0]   count;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   discard;
   logic [CW:0]     credit_used;
   logic            fifo_empty;
   logic            fifo_full;
   logic            grant;
   logic            drop;
   logic            push;
   logic            pop;
   fetch_entry_t    head;
   fetch_entry_t    push_entry;

   assign target_pc   = redirect_pc_i & ~XLEN'(3);
   assign credit_used = {1'b0, count} + {1'b0, inflight};

   // Outstanding requests reserve a queue slot, so a response always has room.
   assign imem_req_o  = resetn_i && !redirect_i && !fifo_full
                        && (credit_used < (CW+1)'(DEPTH));
   assign imem_add_o  = fetch_pc;
   assign grant       = imem_req_o && imem_gnt_i;

   assign drop        = imem_rvalid_i && (discard != '0);
   assign push        = imem_rvalid_i && !drop && !redirect_i;
   assign pop         = inst_valid_o && inst_ready_i && !redirect_i;
   assign push_entry  = '{inst: imem_data_i, pc: resp_pc};

   rv_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_queue (
      .clk_i    (clk_i),
      .resetn_i (resetn_i),
      .flush    (redirect_i),
      .push     (push),
      .wdata    (push_entry),
      .pop      (pop),
      .rdata    (head),
      .count    (count),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= '0;
         discard  <= '0;
      end else if (redirect_i) begin
         // everything still outstanding belongs to the old path and must be dropped
         fetch_pc <= target_pc;
         resp_pc  <= target_pc;
         inflight <= inflight - CW'(imem_rvalid_i);
         discard  <= inflight - CW'(imem_rvalid_i);
      end else begin
         if (grant) fetch_pc <= fetch_pc + XLEN'(4);
         if (push)  resp_pc  <= resp_pc + XLEN'(4);
         if (drop)  discard  <= discard - CW'(1);
         inflight <= inflight + CW'(grant) - CW'(imem_rvalid_i);
      end
   end

   assign inst_valid_o = !fifo_empty;
   assign inst_o       = inst_valid_o ? head.inst : NOP_INSTR;
   assign inst_pc_o    = inst_valid_o ? head.pc : '0;

   a_credit: assert property (@(posedge clk_i) disable iff (!resetn_i)
      credit_used <= (CW+1)'(DEPTH));
   a_rvalid_orphan: assert property (@(posedge clk_i) disable iff (!resetn_i)
      imem_rvalid_i |-> (inflight != '0));

endmodule
